// File: rtl/perturb_pkg.sv
// Shared constants and helpers for the pipelined perturbation engine.
// Optional MutCount statistics output is enabled by defining MUTATE_STATS_EN.
package perturb_pkg;

   localparam int unsigned LFSR_W      = 32;
   localparam logic [31:0] LFSR_POLY   = 32'h80200003;
   localparam logic [31:0] GOLDEN      = 32'h9E3779B9;
   localparam int unsigned MODE_SIGNED = 0;
   localparam int unsigned MODE_SAT    = 1;
   localparam int unsigned MODE_FORCE  = 2;

   // Right-shifting Galois step; taps folded in when the bit shifted out is 1.
   function automatic logic [31:0] lfsr_step(input logic [31:0] r);
      return (r >> 1) ^ (r[0] ? LFSR_POLY : 32'h0);
   endfunction

   // An all-zero LFSR state would lock up, so it is replaced by 1.
   function automatic logic [31:0] lfsr_nonzero(input logic [31:0] v);
      return (v == 32'h0) ? 32'h1 : v;
   endfunction

   function automatic logic [31:0] lane_apply(input logic [31:0] lane,
                                              input logic [31:0] mag,
                                              input logic        neg,
                                              input logic        sat,
                                              input int unsigned width);
      logic [31:0] mask;
      logic [32:0] sum;
      mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      sum  = neg ? ({1'b0, lane} - {1'b0, mag}) : ({1'b0, lane} + {1'b0, mag});
      if (sat && neg && (mag > lane)) begin
         return 32'h0;
      end
      if (sat && !neg && (sum > {1'b0, mask})) begin
         return mask;
      end
      return sum[31:0] & mask;
   endfunction

endpackage

// File: rtl/perturb_lfsr.sv
// One 32-bit Galois LFSR lane: holds, advances one step, or reloads from a seed.
module perturb_lfsr
   import perturb_pkg::*;
#(
   parameter logic [31:0] ResetValue = 32'h1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        advance_i,
   input  logic        load_i,
   input  logic [31:0] seed_i,
   output logic [31:0] state_o
);

   logic [31:0] state_q, state_d;

   // Reload wins over a same-cycle advance.
   always_comb begin
      state_d = state_q;
      if (load_i) begin
         state_d = lfsr_nonzero(seed_i);
      end else if (advance_i) begin
         state_d = lfsr_step(state_q);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= lfsr_nonzero(ResetValue);
      end else begin
         state_q <= state_d;
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/perturbation_engine_pipe.sv
// Two-stage gene perturbation pipeline: stage 1 draws per-lane randoms, stage 2 applies them.
// Define MUTATE_STATS_EN to add the saturating MutCount output.
module perturbation_engine_pipe
   import perturb_pkg::*;
#(
   parameter int unsigned NUM_LANES = 4,
   parameter int unsigned LANE_W    = 8,
   parameter int unsigned PERT_W    = 3,
   parameter int unsigned HDR_W     = 32
) (
   input  logic                              Clk,
   input  logic                              Reset,
   input  logic                              InValid,
   output logic                              InReady,
   input  logic [HDR_W+NUM_LANES*LANE_W-1:0] Crossover,
   input  logic [31:0]                       Threshold,
   input  logic [2:0]                        Mode,
   input  logic                              SeedLoad,
   input  logic [31:0]                       Seed,
   output logic                              OutValid,
   input  logic                              OutReady,
   output logic [HDR_W+NUM_LANES*LANE_W-1:0] ChildGene,
   output logic [NUM_LANES-1:0]              MutMask
`ifdef MUTATE_STATS_EN
   ,
   output logic [31:0]                       MutCount
`endif
);

   localparam int unsigned DataW = HDR_W + NUM_LANES * LANE_W;

   logic                               s1_en, s2_en, accept;
   logic [NUM_LANES-1:0][LFSR_W-1:0]   rnd;
   logic [NUM_LANES-1:0]               sel_d, neg_d;
   logic [NUM_LANES-1:0][PERT_W-1:0]   mag_d;

   logic                               s1_valid_q, s1_sat_q;
   logic [DataW-1:0]                   s1_data_q;
   logic [NUM_LANES-1:0]               s1_sel_q, s1_neg_q;
   logic [NUM_LANES-1:0][PERT_W-1:0]   s1_mag_q;

   logic                               out_valid_q;
   logic [DataW-1:0]                   child_q, child_d;
   logic [NUM_LANES-1:0]               mask_q;

   assign s2_en   = !out_valid_q | OutReady;
   assign s1_en   = !s1_valid_q | s2_en;
   assign InReady = s1_en;
   assign accept  = InValid & s1_en;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      localparam logic [31:0] LaneKey = GOLDEN * 32'(i);

      perturb_lfsr #(
         .ResetValue(32'h1 ^ LaneKey)
      ) u_lfsr (
         .clk_i    (Clk),
         .rst_i    (Reset),
         .advance_i(accept),
         .load_i   (SeedLoad),
         .seed_i   (Seed ^ LaneKey),
         .state_o  (rnd[i])
      );

      assign sel_d[i] = Mode[MODE_FORCE] | (rnd[i] < Threshold);
      assign mag_d[i] = rnd[i][8+PERT_W-1:8];
      assign neg_d[i] = Mode[MODE_SIGNED] & rnd[i][LFSR_W-1];
   end

   always_comb begin
      child_d = s1_data_q;
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
         if (s1_sel_q[l]) begin
            child_d[l*LANE_W +: LANE_W] = LANE_W'(lane_apply(32'(s1_data_q[l*LANE_W +: LANE_W]),
                                                             32'(s1_mag_q[l]), s1_neg_q[l],
                                                             s1_sat_q, LANE_W));
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         s1_valid_q  <= 1'b0;
         s1_sat_q    <= 1'b0;
         s1_data_q   <= '0;
         s1_sel_q    <= '0;
         s1_neg_q    <= '0;
         s1_mag_q    <= '0;
         out_valid_q <= 1'b0;
         child_q     <= '0;
         mask_q      <= '0;
      end else begin
         if (s1_en) begin
            s1_valid_q <= InValid;
         end
         if (accept) begin
            s1_data_q <= Crossover;
            s1_sat_q  <= Mode[MODE_SAT];
            s1_sel_q  <= sel_d;
            s1_neg_q  <= neg_d;
            s1_mag_q  <= mag_d;
         end
         if (s2_en) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               child_q <= child_d;
               mask_q  <= s1_sel_q;
            end
         end
      end
   end

   assign OutValid  = out_valid_q;
   assign ChildGene = child_q;
   assign MutMask   = mask_q;

`ifdef MUTATE_STATS_EN
   logic [31:0] mut_count_q, mut_count_d;
   logic [32:0] mut_sum;
   logic [31:0] mask_pop;

   always_comb begin
      mask_pop = '0;
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
         mask_pop = mask_pop + 32'(mask_q[l]);
      end
      mut_sum     = {1'b0, mut_count_q} + {1'b0, mask_pop};
      mut_count_d = mut_count_q;
      if (SeedLoad) begin
         mut_count_d = '0;
      end else if (out_valid_q && OutReady) begin
         mut_count_d = mut_sum[32] ? 32'hFFFF_FFFF : mut_sum[31:0];
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         mut_count_q <= '0;
      end else begin
         mut_count_q <= mut_count_d;
      end
   end

   assign MutCount = mut_count_q;
`endif

endmodule

// File: tb/tb_perturbation_engine_pipe.sv
// Scoreboard bench: a reference model pushes expected beats on accept, a monitor pops on output.
module tb_perturbation_engine_pipe;

   logic        Clk = 1'b0;
   logic        Reset, InValid, InReady, SeedLoad, OutValid, OutReady;
   logic [63:0] Crossover, ChildGene;
   logic [31:0] Threshold, Seed;
   logic [2:0]  Mode;
   logic [3:0]  MutMask;
`ifdef MUTATE_STATS_EN
   logic [31:0] MutCount;
`endif

   perturbation_engine_pipe #(
      .NUM_LANES(4),
      .LANE_W   (8),
      .PERT_W   (3),
      .HDR_W    (32)
   ) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .InValid  (InValid),
      .InReady  (InReady),
      .Crossover(Crossover),
      .Threshold(Threshold),
      .Mode     (Mode),
      .SeedLoad (SeedLoad),
      .Seed     (Seed),
      .OutValid (OutValid),
      .OutReady (OutReady),
      .ChildGene(ChildGene),
      .MutMask  (MutMask)
`ifdef MUTATE_STATS_EN
      ,
      .MutCount (MutCount)
`endif
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [63:0] gene;
      logic [3:0]  mask;
   } beat_t;

   int          tests = 0;
   int          fails = 0;
   beat_t       exp_q[$];
   logic [31:0] m_lfsr[4];
   longint      m_count = 0;
   int          cyc = 0;
   int          acc_cyc = -1;
   bit          lat_checked = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] m_nz(input logic [31:0] v);
      return (v == 0) ? 32'h1 : v;
   endfunction

   function automatic logic [31:0] m_step(input logic [31:0] r);
      return r[0] ? ((r >> 1) ^ 32'h80200003) : (r >> 1);
   endfunction

   function automatic beat_t m_calc(input logic [63:0] x, input logic [31:0] thr,
                                    input logic [2:0] md);
      beat_t b;
      b.gene = x;
      b.mask = '0;
      for (int l = 0; l < 4; l++) begin
         logic [31:0] r;
         int          s, mag, lane;
         r = m_lfsr[l];
         if (md[2] || (r < thr)) begin
            mag  = int'(r[10:8]);
            lane = int'(x[8*l +: 8]);
            s    = (md[0] && r[31]) ? lane - mag : lane + mag;
            if (md[1]) s = (s > 255) ? 255 : ((s < 0) ? 0 : s);
            else       s = s & 255;
            b.gene[8*l +: 8] = 8'(s);
            b.mask[l]        = 1'b1;
         end
      end
      return b;
   endfunction

   // Reference model: tracks LFSRs and queues expected beats at every accepted transfer.
   always @(posedge Clk) begin
      bit acc;
      if (Reset) begin
         for (int i = 0; i < 4; i++) m_lfsr[i] = m_nz(32'h1 ^ (32'(i) * 32'h9E3779B9));
         exp_q.delete();
         m_count = 0;
      end else begin
         acc = InValid && InReady;
         if (acc) begin
            exp_q.push_back(m_calc(Crossover, Threshold, Mode));
            if (acc_cyc < 0) acc_cyc = cyc;
         end
         if (SeedLoad) begin
            for (int i = 0; i < 4; i++) m_lfsr[i] = m_nz(Seed ^ (32'(i) * 32'h9E3779B9));
            m_count = 0;
         end else if (acc) begin
            for (int i = 0; i < 4; i++) m_lfsr[i] = m_step(m_lfsr[i]);
         end
      end
      cyc++;
   end

   // Monitor: compares every presented beat with the queue head; pops on handshake.
   always @(negedge Clk) begin
      if (!Reset && OutValid) begin
         if (!lat_checked) begin
            lat_checked = 1'b1;
            check("latency", 64'(cyc - acc_cyc), 64'd2);
         end
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got %h expected none", ChildGene);
         end else begin
            check("child_gene", ChildGene, exp_q[0].gene);
            check("mut_mask", 64'(MutMask), 64'(exp_q[0].mask));
            if (OutReady) begin
               m_count += $countones(exp_q[0].mask);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic send(input logic [63:0] x);
      bit ok;
      int n;
      InValid   = 1'b1;
      Crossover = x;
      ok        = 1'b0;
      n         = 0;
      while (!ok && n < 50) begin
         ok = InReady;
         @(posedge Clk);
         #1;
         n++;
      end
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: got InReady=0 expected 1 within 50 cycles");
      end
   endtask

   task automatic idle(input int n);
      InValid = 1'b0;
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic seed_only(input logic [31:0] s);
      InValid  = 1'b0;
      SeedLoad = 1'b1;
      Seed     = s;
      @(posedge Clk);
      #1;
      SeedLoad = 1'b0;
   endtask

   logic [63:0] vec[6] = '{64'h0000_0001_00FF_7F80, 64'hA5A5_5A5A_0102_0304,
                           64'hFFFF_FFFF_FEFD_0100, 64'h1234_5678_8081_7E7F,
                           64'h0BAD_CAFE_0707_F9F9, 64'h5555_AAAA_3C3C_C3C3};

   initial begin
      Reset     = 1'b1;
      InValid   = 1'b0;
      OutReady  = 1'b1;
      SeedLoad  = 1'b0;
      Seed      = '0;
      Crossover = '0;
      Threshold = '0;
      Mode      = '0;
      repeat (3) @(posedge Clk);
      #1;
      Reset = 1'b0;
      check("rst_out_valid", 64'(OutValid), 64'd0);
      check("rst_child", ChildGene, 64'd0);
      check("rst_mask", 64'(MutMask), 64'd0);
      check("rst_in_ready", 64'(InReady), 64'd1);
`ifdef MUTATE_STATS_EN
      check("rst_mut_count", 64'(MutCount), 64'd0);
`endif

      // No mutation at zero threshold
      for (int i = 0; i < 8; i++) send(64'hDEAD_BEEF_1020_3040);
      idle(4);

      // Forced, unsigned, wrapping
      seed_only(32'h1);
      Mode = 3'b100;
      for (int i = 0; i < 4; i++) send(64'hCAFE_F00D_807F_01FF);
      // Forced saturation, both directions
      Mode = 3'b110;
      for (int i = 0; i < 8; i++) send(64'h1234_5678_FEFE_FEFE);
      Mode = 3'b111;
      for (int i = 0; i < 8; i++) send(64'h8765_4321_0101_0101);
      // Probabilistic, signed
      Mode      = 3'b001;
      Threshold = 32'h8000_0000;
      for (int i = 0; i < 6; i++) send(vec[i]);
      idle(4);

      // Backpressure: pipeline fills after two accepts, then stalls
      Mode      = 3'b100;
      Threshold = '0;
      OutReady  = 1'b0;
      send(64'h1111_1111_1111_1111);
      send(64'h2222_2222_2222_2222);
      check("in_ready_full", 64'(InReady), 64'd0);
      InValid   = 1'b1;
      Crossover = 64'h3333_3333_3333_3333;
      repeat (5) begin
         @(posedge Clk);
         #1;
         check("in_ready_stall", 64'(InReady), 64'd0);
      end
      OutReady = 1'b1;
      send(64'h3333_3333_3333_3333);
      idle(4);

      // Seed load of zero coincident with an accept, then reproducible runs
      SeedLoad = 1'b1;
      Seed     = 32'h0;
      send(64'h4444_4444_0000_0000);
      SeedLoad = 1'b0;
      send(64'h5555_5555_0000_0000);
      idle(4);
      for (int run = 0; run < 2; run++) begin
         seed_only(32'h0000_ACE1);
         Mode      = 3'b101;
         Threshold = 32'h6000_0000;
         for (int i = 0; i < 6; i++) send(vec[i]);
         idle(4);
      end

      // Reset with two beats in flight
      Mode      = 3'b100;
      Threshold = '0;
      OutReady  = 1'b0;
      send(64'h6666_6666_6666_6666);
      send(64'h7777_7777_7777_7777);
      InValid = 1'b0;
      Reset   = 1'b1;
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      check("flush_out_valid", 64'(OutValid), 64'd0);
      check("flush_child", ChildGene, 64'd0);
`ifdef MUTATE_STATS_EN
      check("flush_mut_count", 64'(MutCount), 64'd0);
`endif
      OutReady = 1'b1;
      idle(4);
      for (int i = 0; i < 4; i++) send(vec[i]);
      idle(4);
`ifdef MUTATE_STATS_EN
      check("mut_count", 64'(MutCount), 64'(m_count));
      check("mut_count_hand", 64'(MutCount), 64'd16);
`endif
      check("drain", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
